// File: rtl/sync_edge.sv
// N-flop input synchronizer with a one-cycle-delayed copy and rise/fall strobes.
// STAGES=0 bypasses the flops for inputs already in the clk_i domain.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic sync_o,
    output logic prev_o,
    output logic rise_o,
    output logic fall_o
);

    generate
        if (STAGES > 0) begin : g_sync
            logic [STAGES-1:0] chain_q;

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    chain_q <= {STAGES{RESET_VAL}};
                end else begin
                    chain_q[0] <= d_i;
                    for (int i = 1; i < STAGES; i++) begin
                        chain_q[i] <= chain_q[i-1];
                    end
                end
            end

            assign sync_o = chain_q[STAGES-1];
        end else begin : g_bypass
            assign sync_o = d_i;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_o <= RESET_VAL;
        end else begin
            prev_o <= sync_o;
        end
    end

    assign rise_o = sync_o & ~prev_o;
    assign fall_o = ~sync_o & prev_o;

endmodule

// File: rtl/shift_reg_rx.sv
// Serial receiver for the sclk/data/latch shift chain: rebuilds the word MSB-first
// and publishes it on latch rise when exactly WIDTH bits were clocked in.
module shift_reg_rx #(
    parameter int WIDTH       = 48,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sclk_i,
    input  logic             data_i,
    input  logic             latch_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             frame_err_o,
    output logic             busy_o
);

    localparam int               CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    logic             sclk_rise;
    logic             lat_q;
    logic             lat_rise;
    logic             lat_fall;
    logic             data_sync;
    logic             end_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] sreg_q;

    logic unused_sclk_sync, unused_sclk_prev, unused_sclk_fall;
    logic unused_lat_sync;
    logic unused_data_prev, unused_data_rise, unused_data_fall;

    // sclk idles high and latch idles low in reset so release produces no edges.
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (sclk_i),
        .sync_o (unused_sclk_sync),
        .prev_o (unused_sclk_prev),
        .rise_o (sclk_rise),
        .fall_o (unused_sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_latch (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (latch_i),
        .sync_o (unused_lat_sync),
        .prev_o (lat_q),
        .rise_o (lat_rise),
        .fall_o (lat_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (data_i),
        .sync_o (data_sync),
        .prev_o (unused_data_prev),
        .rise_o (unused_data_rise),
        .fall_o (unused_data_fall)
    );

    // Shifting is gated by busy_o so a frame cut by reset is ignored until the next latch fall.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
            end_q       <= 1'b0;
            count_q     <= '0;
            sreg_q      <= '0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            end_q       <= lat_rise;

            if (sclk_rise && !lat_q && busy_o) begin
                sreg_q <= {sreg_q[WIDTH-2:0], data_sync};
                if (count_q != CNT_SAT) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end

            // Evaluated one cycle after the synced latch rise so a coincident last shift is counted.
            if (end_q && busy_o) begin
                busy_o <= 1'b0;
                if (count_q == CNT_FULL) begin
                    data_o  <= sreg_q;
                    valid_o <= 1'b1;
                end else if (count_q != '0) begin
                    frame_err_o <= 1'b1;
                end
            end

            if (lat_fall) begin
                count_q <= '0;
                busy_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_rx.sv
// Directed bench for shift_reg_rx: a 2-stage synchronized instance and a
// SYNC_STAGES=0 instance used for a fast random-word loopback run.
module tb_shift_reg_rx;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        sclk_d [2];
    logic        data_d [2];
    logic        latch_d[2];
    logic [47:0] dout   [2];
    logic        valid  [2];
    logic        ferr   [2];
    logic        busy   [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    shift_reg_rx #(.WIDTH(48), .SYNC_STAGES(2)) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sclk_i      (sclk_d[0]),
        .data_i      (data_d[0]),
        .latch_i     (latch_d[0]),
        .data_o      (dout[0]),
        .valid_o     (valid[0]),
        .frame_err_o (ferr[0]),
        .busy_o      (busy[0])
    );

    shift_reg_rx #(.WIDTH(48), .SYNC_STAGES(0)) u_lb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sclk_i      (sclk_d[1]),
        .data_i      (data_d[1]),
        .latch_i     (latch_d[1]),
        .data_o      (dout[1]),
        .valid_o     (valid[1]),
        .frame_err_o (ferr[1]),
        .busy_o      (busy[1])
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: leave latch low, 1: raise latch after last bit, 2: raise latch with last sclk rise
    task automatic send_frame(input int sel, input logic [63:0] w, input int nbits,
                              input int ph, input int mode, output logic busy_mid);
        busy_mid = 1'b0;
        latch_d[sel] = 1'b0;
        repeat (ph) step();
        for (int i = nbits - 1; i >= 0; i--) begin
            sclk_d[sel] = 1'b0;
            data_d[sel] = w[i];
            repeat (ph) step();
            sclk_d[sel] = 1'b1;
            if (mode == 2 && i == 0) latch_d[sel] = 1'b1;
            repeat (ph) step();
            if (i == nbits / 2) busy_mid = busy[sel];
        end
        if (mode == 1) latch_d[sel] = 1'b1;
    endtask

    task automatic collect(input int sel, input int ncyc, output int nv, output int ne,
                           output int both, output int lat, output logic [47:0] dat);
        nv = 0; ne = 0; both = 0; lat = -1; dat = '0;
        for (int c = 1; c <= ncyc; c++) begin
            step();
            if (valid[sel]) begin
                nv++;
                if (lat < 0) lat = c;
                dat = dout[sel];
            end
            if (ferr[sel]) begin
                ne++;
                if (lat < 0) lat = c;
            end
            if (valid[sel] && ferr[sel]) both++;
        end
    endtask

    initial begin
        int          nv, ne, both, lat, lb_err;
        logic [47:0] dat, w;
        logic        bm;

        for (int s = 0; s < 2; s++) begin
            sclk_d[s] = 1'b1; data_d[s] = 1'b0; latch_d[s] = 1'b1;
        end
        repeat (3) step();
        chk("rst_data", {16'h0, dout[0]}, 64'h0);
        chk("rst_valid", {63'h0, valid[0]}, 64'h0);
        chk("rst_err", {63'h0, ferr[0]}, 64'h0);
        chk("rst_busy", {63'h0, busy[0]}, 64'h0);
        rst_ni = 1'b1;
        repeat (4) step();

        // Basic 48-bit frame, latch rise to pulse in SYNC_STAGES+2 cycles
        send_frame(0, 64'hA5A5_0F0F_C3C3, 48, 2, 1, bm);
        chk("busy_mid", {63'h0, bm}, 64'h1);
        collect(0, 8, nv, ne, both, lat, dat);
        chk("f1_valid", 64'(nv), 64'd1);
        chk("f1_err", 64'(ne), 64'd0);
        chk("f1_data", {16'h0, dat}, 64'hA5A5_0F0F_C3C3);
        chk("f1_latency", 64'(lat), 64'd4);
        chk("f1_busy_after", {63'h0, busy[0]}, 64'h0);

        send_frame(0, 64'h7FFF_FFFF_FFFF, 47, 2, 1, bm);
        collect(0, 8, nv, ne, both, lat, dat);
        chk("short_err", 64'(ne), 64'd1);
        chk("short_valid", 64'(nv), 64'd0);
        chk("short_hold", {16'h0, dout[0]}, 64'hA5A5_0F0F_C3C3);

        send_frame(0, 64'h3_1234_5678_9ABC, 50, 2, 1, bm);
        collect(0, 8, nv, ne, both, lat, dat);
        chk("long_err", 64'(ne), 64'd1);
        chk("long_valid", 64'(nv), 64'd0);
        chk("long_hold", {16'h0, dout[0]}, 64'hA5A5_0F0F_C3C3);

        send_frame(0, 64'h0, 0, 3, 1, bm);
        collect(0, 8, nv, ne, both, lat, dat);
        chk("empty_valid", 64'(nv), 64'd0);
        chk("empty_err", 64'(ne), 64'd0);

        // sclk activity while latch is high must not count
        for (int k = 0; k < 4; k++) begin
            sclk_d[0] = 1'b0; data_d[0] = 1'b1; repeat (2) step();
            sclk_d[0] = 1'b1; repeat (2) step();
        end
        send_frame(0, 64'h1234_5678_9ABC, 48, 2, 1, bm);
        collect(0, 8, nv, ne, both, lat, dat);
        chk("idle_tog_valid", 64'(nv), 64'd1);
        chk("idle_tog_err", 64'(ne), 64'd0);
        chk("idle_tog_data", {16'h0, dat}, 64'h1234_5678_9ABC);

        send_frame(0, 64'h0123_4567_89AB, 48, 2, 2, bm);
        collect(0, 8, nv, ne, both, lat, dat);
        chk("simul_valid", 64'(nv), 64'd1);
        chk("simul_err", 64'(ne), 64'd0);
        chk("simul_data", {16'h0, dat}, 64'h0123_4567_89AB);

        // Reset in the middle of a frame
        send_frame(0, 64'hFFFF_FFFF_FFFF, 20, 2, 0, bm);
        rst_ni = 1'b0;
        repeat (2) step();
        chk("midrst_data", {16'h0, dout[0]}, 64'h0);
        chk("midrst_valid", {63'h0, valid[0]}, 64'h0);
        chk("midrst_err", {63'h0, ferr[0]}, 64'h0);
        chk("midrst_busy", {63'h0, busy[0]}, 64'h0);
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sclk_d[0] = 1'b0; data_d[0] = 1'b1; repeat (2) step();
            sclk_d[0] = 1'b1; repeat (2) step();
        end
        latch_d[0] = 1'b1;
        collect(0, 8, nv, ne, both, lat, dat);
        chk("abort_valid", 64'(nv), 64'd0);
        chk("abort_err", 64'(ne), 64'd0);
        send_frame(0, 64'hFFFF_FFFF_FFFF, 48, 2, 1, bm);
        collect(0, 8, nv, ne, both, lat, dat);
        chk("ones_valid", 64'(nv), 64'd1);
        chk("ones_err", 64'(ne), 64'd0);
        chk("ones_data", {16'h0, dat}, 64'hFFFF_FFFF_FFFF);
        chk("ones_hold", {16'h0, dout[0]}, 64'hFFFF_FFFF_FFFF);

        // Unsynchronized instance, single-cycle phases, random words
        lb_err = 0;
        for (int n = 0; n < 100; n++) begin
            w = 48'({$urandom, $urandom});
            send_frame(1, {16'h0, w}, 48, 1, 1, bm);
            collect(1, 6, nv, ne, both, lat, dat);
            lb_err += ne + both;
            chk("lb_valid", 64'(nv), 64'd1);
            chk("lb_data", {16'h0, dat}, {16'h0, w});
        end
        chk("lb_errors", 64'(lb_err), 64'd0);
        chk("lb_latency", 64'(lat), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
